// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter: merges the commit streams of the execute units for one
// issue slot into a single registered commit stream.
//   - Round-robin arbitration. The pointer moves past a source only when that
//     source's eop beat is accepted.
//   - A multi-beat packet keeps the grant on its source from sop through eop.
//   - Optional 64-bit performance counters, built only when COMMIT_PERF_EN is
//     defined. Without it, the perf outputs are tied to 0.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready per-source beat handshake (in_ready is combinational)
//   in_data/in_tmask  per-source payload and thread mask
//   in_sop/in_eop     per-source packet framing
//   out_valid/ready   registered output handshake
//   out_data/tmask    output payload and thread mask
//   out_sop/eop/src   output framing and source ID
//   perf_instrs       retired instructions (accepted eop beats)
//   perf_threads      retired thread-instructions (popcount of accepted tmask)
//   perf_stalls       cycles with out_valid && !out_ready
module vx_commit_arbiter #(
  parameter int unsigned NUM_SRCS    = 5,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned DATAW       = 128
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_SRCS-1:0]                   in_valid,
  output logic [NUM_SRCS-1:0]                   in_ready,
  input  logic [NUM_SRCS-1:0][DATAW-1:0]        in_data,
  input  logic [NUM_SRCS-1:0][NUM_THREADS-1:0]  in_tmask,
  input  logic [NUM_SRCS-1:0]                   in_sop,
  input  logic [NUM_SRCS-1:0]                   in_eop,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATAW-1:0]                      out_data,
  output logic [NUM_THREADS-1:0]                out_tmask,
  output logic                                  out_sop,
  output logic                                  out_eop,
  output logic [$clog2(NUM_SRCS)-1:0]           out_src,
  output logic [63:0]                           perf_instrs,
  output logic [63:0]                           perf_threads,
  output logic [63:0]                           perf_stalls
);

  localparam int unsigned SRCW = $clog2(NUM_SRCS);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state, state_nxt;
  logic [SRCW-1:0] lock_src, lock_src_nxt;
  logic [SRCW-1:0] rr_ptr, rr_ptr_nxt;

  logic                scan_any;
  logic [SRCW-1:0]     scan_idx;
  int unsigned         scan_pos;
  logic                gnt_any;
  logic [SRCW-1:0]     gnt_idx;
  logic [NUM_SRCS-1:0] grant_c;
  logic                load_c;
  logic                accept_c;
  logic                beat_sop;
  logic                beat_eop;

  // The output register can take a new beat when it is empty or draining.
  assign load_c   = !out_valid || out_ready;
  assign accept_c = load_c && gnt_any;
  assign beat_sop = in_sop[gnt_idx];
  assign beat_eop = in_eop[gnt_idx];
  assign in_ready = load_c ? grant_c : '0;

  // Round-robin scan: first valid source at or after rr_ptr, modulo NUM_SRCS.
  always_comb begin
    scan_any = 1'b0;
    scan_idx = '0;
    scan_pos = 0;
    for (int unsigned k = 0; k < NUM_SRCS; k++) begin
      scan_pos = (32'(rr_ptr) + k) % NUM_SRCS;
      if (!scan_any && in_valid[SRCW'(scan_pos)]) begin
        scan_any = 1'b1;
        scan_idx = SRCW'(scan_pos);
      end
    end
  end

  // Lock state, lock source and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lock_src <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      lock_src <= lock_src_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // Next-state and grant selection. While locked, only the lock owner can be
  // granted, even when it is momentarily not valid.
  always_comb begin
    state_nxt    = state;
    lock_src_nxt = lock_src;
    rr_ptr_nxt   = rr_ptr;
    gnt_any      = scan_any;
    gnt_idx      = scan_idx;
    grant_c      = '0;

    case (state)
      IDLE: begin
        if (accept_c && beat_sop && !beat_eop) begin
          state_nxt    = LOCKED;
          lock_src_nxt = gnt_idx;
        end
      end
      LOCKED: begin
        gnt_any = in_valid[lock_src];
        gnt_idx = lock_src;
        if (accept_c && beat_eop) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (gnt_any) begin
      grant_c[gnt_idx] = 1'b1;
    end

    // The pointer moves only past a source whose packet has completed.
    if (accept_c && beat_eop) begin
      rr_ptr_nxt = (gnt_idx == SRCW'(NUM_SRCS - 1)) ? '0 : gnt_idx + SRCW'(1);
    end
  end

  // Output register. Without a grant the payload holds and only valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tmask <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_src   <= '0;
    end else if (load_c) begin
      out_valid <= gnt_any;
      if (gnt_any) begin
        out_data  <= in_data[gnt_idx];
        out_tmask <= in_tmask[gnt_idx];
        out_sop   <= beat_sop;
        out_eop   <= beat_eop;
        out_src   <= gnt_idx;
      end
    end
  end

`ifdef COMMIT_PERF_EN
  // Performance counters, wrapping modulo 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_instrs  <= '0;
      perf_threads <= '0;
      perf_stalls  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        perf_threads <= perf_threads + 64'($countones(out_tmask));
        if (out_eop) begin
          perf_instrs <= perf_instrs + 64'd1;
        end
      end
      if (out_valid && !out_ready) begin
        perf_stalls <= perf_stalls + 64'd1;
      end
    end
  end
`else
  assign perf_instrs  = '0;
  assign perf_threads = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Randomized bench for vx_commit_arbiter with a transaction-level reference
// model. The model tracks the open packet and the source of the last
// completed packet, and picks the next grant from those.
module tb_vx_commit_arbiter;

  localparam int NS = 5;
  localparam int NT = 4;
  localparam int DW = 128;
  localparam int SW = 3;

  logic                      clk;
  logic                      reset;
  logic [NS-1:0]             in_valid;
  logic [NS-1:0]             in_ready;
  logic [NS-1:0][DW-1:0]     in_data;
  logic [NS-1:0][NT-1:0]     in_tmask;
  logic [NS-1:0]             in_sop;
  logic [NS-1:0]             in_eop;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW-1:0]             out_data;
  logic [NT-1:0]             out_tmask;
  logic                      out_sop;
  logic                      out_eop;
  logic [SW-1:0]             out_src;
  logic [63:0]               perf_instrs;
  logic [63:0]               perf_threads;
  logic [63:0]               perf_stalls;

  vx_commit_arbiter #(.NUM_SRCS(NS), .NUM_THREADS(NT), .DATAW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_tmask     (in_tmask),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tmask    (out_tmask),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_src      (out_src),
    .perf_instrs  (perf_instrs),
    .perf_threads (perf_threads),
    .perf_stalls  (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [NT-1:0] tmask;
    logic          sop;
    logic          eop;
  } beat_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_valid;
  beat_t       m_beat;
  int          m_src;
  bit          m_clean;      // output fields still hold their reset zeros
  int          last_done;    // source of the last completed packet
  int          open_src;     // source with a packet in flight, -1 if none
  logic [63:0] m_instrs, m_threads, m_stalls;

  // Stimulus state and knobs
  bit    pres [NS];
  beat_t cur  [NS];
  int    rem  [NS];
  int    p_valid, p_ready, force_single, fix_tmask, budget;
  logic [NS-1:0] src_en;

  function automatic logic [63:0] exp_perf(input logic [63:0] v);
`ifdef COMMIT_PERF_EN
    return v;
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_beat    = '{data: '0, tmask: '0, sop: 1'b0, eop: 1'b0};
    m_src     = 0;
    m_clean   = 1'b1;
    last_done = NS - 1;
    open_src  = -1;
    m_instrs  = '0;
    m_threads = '0;
    m_stalls  = '0;
    for (int i = 0; i < NS; i++) begin
      pres[i] = 1'b0;
      rem[i]  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_src", out_src, '0);
    check("rst_instrs", perf_instrs, '0);
    check("rst_threads", perf_threads, '0);
    check("rst_stalls", perf_stalls, '0);
  endtask

  task automatic run(input int cycles);
    int    g;
    int    idx;
    int    len;
    bit    load;
    logic [NS-1:0] exp_rdy;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      // Sources present a new beat only when the previous one was taken.
      for (int i = 0; i < NS; i++) begin
        if (!pres[i] && $urandom_range(99) < p_valid) begin
          if (rem[i] > 0) begin
            cur[i].sop = 1'b0;
            cur[i].eop = (rem[i] == 1);
            rem[i]--;
            pres[i] = 1'b1;
          end else if (src_en[i] && budget != 0) begin
            len = force_single ? 1 : int'($urandom_range(1, 3));
            if (budget > 0) budget--;
            cur[i].sop = 1'b1;
            cur[i].eop = (len == 1);
            rem[i] = len - 1;
            pres[i] = 1'b1;
          end
          if (pres[i]) begin
            cur[i].data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            cur[i].tmask = fix_tmask ? 4'b1011 : NT'($urandom());
          end
        end
        in_valid[i] = pres[i];
        in_data[i]  = pres[i] ? cur[i].data : '0;
        in_tmask[i] = pres[i] ? cur[i].tmask : '0;
        in_sop[i]   = pres[i] ? cur[i].sop : 1'b0;
        in_eop[i]   = pres[i] ? cur[i].eop : 1'b0;
      end
      out_ready = ($urandom_range(99) < p_ready);
      #1;

      // Registered outputs against the model.
      check("out_valid", out_valid, m_valid);
      if (m_valid || m_clean) begin
        check("out_data", out_data, m_beat.data);
        check("out_tmask", out_tmask, m_beat.tmask);
        check("out_sop", out_sop, m_beat.sop);
        check("out_eop", out_eop, m_beat.eop);
        check("out_src", out_src, m_src);
      end
      check("perf_instrs", perf_instrs, exp_perf(m_instrs));
      check("perf_threads", perf_threads, exp_perf(m_threads));
      check("perf_stalls", perf_stalls, exp_perf(m_stalls));

      // Expected grant: the open packet's owner, else round-robin after the
      // last completed packet.
      g = -1;
      if (open_src >= 0) begin
        if (pres[open_src]) g = open_src;
      end else begin
        for (int k = 0; k < NS; k++) begin
          idx = (last_done + 1 + k) % NS;
          if (g < 0 && pres[idx]) g = idx;
        end
      end
      load = !m_valid || out_ready;
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", in_ready, exp_rdy);

      // Advance the model across the coming clock edge.
      if (m_valid && out_ready) begin
        m_threads += 64'($countones(m_beat.tmask));
        if (m_beat.eop) m_instrs += 64'd1;
      end
      if (m_valid && !out_ready) m_stalls += 64'd1;
      if (load) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_beat  = cur[g];
          m_src   = g;
          m_clean = 1'b0;
          if (cur[g].eop) begin
            last_done = g;
            open_src  = -1;
          end else begin
            open_src = g;
          end
          pres[g] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_tmask  = '0;
    in_sop    = '0;
    in_eop    = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NS; i++) cur[i] = '{data: '0, tmask: '0, sop: 1'b0, eop: 1'b0};
    model_reset();
    repeat (2) @(negedge clk);

    // Source 2 alone: eight single-beat packets, tmask 1011, no backpressure.
    do_reset();
    src_en = 5'b00100; p_valid = 100; p_ready = 100;
    force_single = 1; fix_tmask = 1; budget = 8;
    run(12);
    check("a_instrs", perf_instrs, exp_perf(64'd8));
    check("a_threads", perf_threads, exp_perf(64'd24));

    // All sources valid, single-beat packets: strict 0,1,2,3,4 rotation.
    do_reset();
    src_en = '1; p_valid = 100; p_ready = 100;
    force_single = 1; fix_tmask = 0; budget = -1;
    run(30);

    // Multi-beat packets with gaps and random backpressure.
    src_en = '1; p_valid = 60; p_ready = 60; force_single = 0;
    run(1500);

    // Heavy backpressure and sparse sources.
    p_valid = 35; p_ready = 25;
    run(800);

    // Reset in the middle of traffic, then continue.
    do_reset();
    p_valid = 80; p_ready = 70;
    run(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
